pipe_hazard_unit: RTL
=====================

# pipe_hazard_unit

Parametrised hazard-detection and operand-forwarding controller for the in-order pipeline. Tracks destination registers of in-flight instructions in a shift-register scoreboard covering EX through the last forwarding stage. Raises a load-use stall at decode, and computes a registered per-source forward select for the instruction entering EX. Muxes forwarded data onto the EX operand buses. Generalises the fixed two-source MEM/WB forwarding to arbitrary register count, source count, forwarding depth and load latency, and adds stall generation and a stall counter.

## Interface
- DATA_W, 32, operand width
- REG_AW, 3, register-address width
- NUM_SRC, 2, source operands per instruction
- FWD_DEPTH, 2, forwarding stages after EX (1 = MEM, 2 = WB, …)
- LOAD_LAT, 1, extra stages before load data is forwardable (1 ≤ LOAD_LAT < FWD_DEPTH)
- ZERO_REG, 0, when 1, register 0 never creates a hazard or forward
- SEL_W, derived, $clog2(FWD_DEPTH+1)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- dec_valid  in  1  decode holds a real instruction
- dec_src  in  NUM_SRC*REG_AW  source register addresses, source i at [i*REG_AW +: REG_AW]
- dec_src_used  in  NUM_SRC  source i is actually read
- dec_dst  in  REG_AW  destination register
- dec_wen  in  1  instruction writes dec_dst
- dec_is_load  in  1  instruction is a memory load
- flush  in  1  branch/jump redirect; kill the decode instruction
- rf_data  in  NUM_SRC*DATA_W  register-file operands already registered into EX
- stage_data  in  FWD_DEPTH*DATA_W  result of stage EX+k at slot k-1
- stall  out  1  hold fetch/decode, insert bubble into EX (combinational)
- ex_valid  out  1  EX holds a real instruction
- ex_fwd_sel  out  NUM_SRC*SEL_W  per-source select: 0 = rf_data, k = stage_data slot k-1
- ex_src_data  out  NUM_SRC*DATA_W  forwarded EX operands
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Scoreboard entry e[p], p = 0..FWD_DEPTH-1, holds {valid, wen, dst, is_load} for the instruction in stage EX+p.
- Every cycle: e[p+1] ← e[p]; the oldest entry drops out. Write-back beyond the window is covered by the write-through register file.
- e[0] ← decode info when dec_valid & !stall & !flush. Otherwise e[0] ← bubble (valid = 0).
- A match for source i at entry p requires all of:
  - e[p].valid and e[p].wen
  - e[p].dst == dec_src[i]
  - dec_src_used[i]
  - not (ZERO_REG && dec_src[i] == 0)
- The youngest (lowest p) match wins.
- Load-use stall: stall = dec_valid & !flush & OR over sources of (youngest match is a load with p < LOAD_LAT).
- Registered select: when decode advances, ex_fwd_sel[i] ← p+1 for the youngest match, else 0. On bubble, all selects ← 0 and ex_valid ← 0.
- ex_src_data[i] = (sel == 0) ? rf_data[i] : stage_data[sel-1], combinational from the registered select.
- stall_cnt increments on each stall cycle and saturates at 16'hFFFF.

## Timing
- Reset (rst low, asynchronous): all entries invalid; ex_valid = 0; ex_fwd_sel = 0; stall_cnt = 0; stall = 0.
- Reset mid-stall clears the stall immediately.
- stall and ex_src_data are combinational. ex_fwd_sel and ex_valid update one clock after decode advances.
- ALU producer → consumer at distance d (1..FWD_DEPTH): no stall; select = d.
- Load producer → consumer at distance d ≤ LOAD_LAT: stall for (LOAD_LAT+1-d) cycles, then select = LOAD_LAT+1.
- flush and stall in the same cycle: flush wins; stall = 0, bubble into EX, stall_cnt unchanged.
- The stalled instruction re-evaluates each cycle; stall deasserts once the load reaches entry LOAD_LAT.

## Structure
- Package pipe_pkg holds:
  - scoreboard entry struct
  - SEL_W function
  - select encodings: SEL_RF = 0
- Sub-module hazard_match: combinational youngest-match priority encoder per source. It returns the hit flag, index and is_load, and is instantiated NUM_SRC times.

## Test plan
- Reset: drive a load-use stall, pull rst low mid-cycle → stall = 0, ex_valid = 0, ex_fwd_sel = 0, stall_cnt = 0 immediately.
- ALU back-to-back: write r1, next cycle read src0 = r1 → no stall; ex_fwd_sel[0] = 1; ex_src_data[0] = stage_data slot 0 = 32'hDEADBEEF.
- Distance 2: write r4, one unrelated instruction, then read src1 = r4 → ex_fwd_sel[1] = 2; output equals stage_data slot 1.
- Load-use: load r2, next cycle read src1 = r2 → stall exactly 1 cycle; stall_cnt = 1; then ex_fwd_sel[1] = 2.
  - Same sequence with dec_src_used[1] = 0 → no stall.
- Youngest wins: two consecutive writes to r3, then read r3 → select = 1, not 2.
- Flush collision: load-use stall with flush = 1 in the same cycle → stall = 0; next cycle ex_valid = 0; stall_cnt unchanged.
  - ZERO_REG = 1: load r0 then read r0 → no stall; select = 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard / forwarding controller.
package pipe_pkg;

  // Scoreboard destinations are stored at this fixed width so the entry type
  // can live in a package; REG_AW must not exceed it.
  localparam int MAX_REG_AW = 8;

  // Select encoding for "no forward, take the register-file operand".
  localparam int SEL_RF = 0;

  typedef struct packed {
    logic                  valid;
    logic                  wen;
    logic [MAX_REG_AW-1:0] dst;
    logic                  is_load;
  } sb_entry_t;

  function automatic int sel_width(input int fwd_depth);
    return $clog2(fwd_depth + 1);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit_match.sv
// Youngest-match priority encoder for one decode source against the scoreboard.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int REG_AW    = 3,
  parameter int FWD_DEPTH = 2,
  parameter bit ZERO_REG  = 1'b0,
  parameter int SEL_W     = sel_width(FWD_DEPTH)
) (
  input  sb_entry_t [FWD_DEPTH-1:0] entries_i,
  input  logic      [REG_AW-1:0]    src_i,
  input  logic                      used_i,
  output logic                      hit_o,
  output logic      [SEL_W-1:0]     idx_o,
  output logic                      is_load_o
);

  logic src_ok;

  assign src_ok = used_i && !(ZERO_REG && (src_i == '0));

  // NOTE: every output gets a default before the loop, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    hit_o     = 1'b0;
    idx_o     = '0;
    is_load_o = 1'b0;
    // Walk oldest to youngest so the youngest match is the last one written.
    for (int p = FWD_DEPTH - 1; p >= 0; p--) begin
      if (src_ok && entries_i[p].valid && entries_i[p].wen &&
          (entries_i[p].dst == MAX_REG_AW'(src_i))) begin
        hit_o     = 1'b1;
        idx_o     = SEL_W'(p);
        is_load_o = entries_i[p].is_load;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Load-use stall generation and operand forwarding for the in-order pipeline,
// driven by a shift-register scoreboard of in-flight destinations.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_AW    = 3,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int LOAD_LAT  = 1,
  parameter bit ZERO_REG  = 1'b0,
  parameter int SEL_W     = sel_width(FWD_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dec_valid,
  input  logic [NUM_SRC*REG_AW-1:0]    dec_src,
  input  logic [NUM_SRC-1:0]           dec_src_used,
  input  logic [REG_AW-1:0]            dec_dst,
  input  logic                         dec_wen,
  input  logic                         dec_is_load,
  input  logic                         flush,
  input  logic [NUM_SRC*DATA_W-1:0]    rf_data,
  input  logic [FWD_DEPTH*DATA_W-1:0]  stage_data,
  output logic                         stall,
  output logic                         ex_valid,
  output logic [NUM_SRC*SEL_W-1:0]     ex_fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0]    ex_src_data,
  output logic [15:0]                  stall_cnt
);

  localparam logic [SEL_W-1:0] SEL_RF_W = SEL_W'(SEL_RF);

  sb_entry_t [FWD_DEPTH-1:0]  sb_q, sb_d;
  logic [NUM_SRC*SEL_W-1:0]   sel_q, sel_d;
  logic                       ex_valid_q;
  logic [15:0]                stall_cnt_q;

  logic [NUM_SRC-1:0]         hit, is_load, load_use;
  logic [SEL_W-1:0]           idx [NUM_SRC];
  logic                       advance;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    hazard_match #(
      .REG_AW   (REG_AW),
      .FWD_DEPTH(FWD_DEPTH),
      .ZERO_REG (ZERO_REG),
      .SEL_W    (SEL_W)
    ) u_match (
      .entries_i(sb_q),
      .src_i    (dec_src[i*REG_AW +: REG_AW]),
      .used_i   (dec_src_used[i]),
      .hit_o    (hit[i]),
      .idx_o    (idx[i]),
      .is_load_o(is_load[i])
    );

    // A load in entry p has its data forwardable only once p reaches LOAD_LAT.
    assign load_use[i] = hit[i] && is_load[i] && (idx[i] < SEL_W'(LOAD_LAT));
  end

  assign stall   = dec_valid && !flush && (|load_use);
  assign advance = dec_valid && !flush && !stall;

  always_comb begin
    sb_d = '0;
    for (int p = 1; p < FWD_DEPTH; p++) begin
      sb_d[p] = sb_q[p-1];
    end
    if (advance) begin
      sb_d[0].valid   = 1'b1;
      sb_d[0].wen     = dec_wen;
      sb_d[0].dst     = MAX_REG_AW'(dec_dst);
      sb_d[0].is_load = dec_is_load;
    end

    sel_d = {NUM_SRC{SEL_RF_W}};
    if (advance) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (hit[i]) sel_d[i*SEL_W +: SEL_W] = idx[i] + SEL_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the scoreboard is tiny and is reset like any register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q        <= '0;
      sel_q       <= {NUM_SRC{SEL_RF_W}};
      ex_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      sb_q       <= sb_d;
      sel_q      <= sel_d;
      ex_valid_q <= advance;
      if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  always_comb begin
    ex_src_data = rf_data;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        if (sel_q[i*SEL_W +: SEL_W] == SEL_W'(k))
          ex_src_data[i*DATA_W +: DATA_W] = stage_data[(k-1)*DATA_W +: DATA_W];
      end
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_fwd_sel = sel_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
